// File: rtl/tl_ctrl.sv
// Traffic-light sequencing controller: INIT -> GREEN -> YELLOW -> RED -> GREEN ...
// Adds run enable, pedestrian early GREEN termination, phase watchdog and a cycle counter.
module tl_ctrl #(
  parameter int unsigned MIN_G   = 128,
  parameter int unsigned TIMEOUT = 2047,
  parameter int unsigned PT_W    = 11
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       en,
  input  logic [3:0] int_flags,
  input  logic       ped_req,
  output logic [3:0] cmd_flags,
  output logic       cnt_rst,
  output logic       ped_ack,
  output logic [7:0] cycle_cnt,
  output logic       err
);

  localparam int unsigned INT_INIT = 0;
  localparam int unsigned INT_G    = 1;
  localparam int unsigned INT_Y    = 2;
  localparam int unsigned INT_R    = 3;
  localparam int unsigned CMD_INIT = 0;
  localparam int unsigned CMD_G    = 1;
  localparam int unsigned CMD_Y    = 2;
  localparam int unsigned CMD_R    = 3;

  localparam logic [PT_W-1:0] T_LAST  = PT_W'(TIMEOUT - 1);
  localparam logic [PT_W-1:0] T_SAT   = PT_W'(TIMEOUT);
  localparam logic [PT_W-1:0] T_MING  = PT_W'(MIN_G);
  localparam logic [PT_W-1:0] T_BLANK = PT_W'(2);

  typedef enum logic [2:0] {
    S_IDLE,
    S_INIT,
    S_GREEN,
    S_YELLOW,
    S_RED
  } state_e;

  state_e          state_q;
  state_e          next_phase;
  logic [PT_W-1:0] timer_q;
  logic [PT_W-1:0] timer_d;
  logic [3:0]      cmd_q;
  logic            cnt_rst_q;
  logic            ped_ack_q;
  logic            err_q;
  logic            pend_q;
  logic [7:0]      cnt_q;
  logic            flag_hit;
  logic            ped_end;
  logic            advance;
  logic            wd_hit;

  function automatic logic [3:0] cmd_of(input state_e s);
    logic [3:0] c;
    c = '0;
    case (s)
      S_INIT:   c[CMD_INIT] = 1'b1;
      S_GREEN:  c[CMD_G]    = 1'b1;
      S_YELLOW: c[CMD_Y]    = 1'b1;
      S_RED:    c[CMD_R]    = 1'b1;
      default:  c = '0;
    endcase
    return c;
  endfunction

  always_comb begin
    flag_hit   = 1'b0;
    next_phase = S_IDLE;
    case (state_q)
      S_INIT:   begin flag_hit = int_flags[INT_INIT]; next_phase = S_GREEN;  end
      S_GREEN:  begin flag_hit = int_flags[INT_G];    next_phase = S_YELLOW; end
      S_YELLOW: begin flag_hit = int_flags[INT_Y];    next_phase = S_RED;    end
      S_RED:    begin flag_hit = int_flags[INT_R];    next_phase = S_GREEN;  end
      default:  begin flag_hit = 1'b0;                next_phase = S_IDLE;   end
    endcase
    // Timer values 0 and 1 form the blanking window; stale flags are ignored there.
    ped_end = (state_q == S_GREEN) && pend_q && (timer_q >= T_MING);
    advance = ((timer_q >= T_BLANK) && flag_hit) || ped_end;
    // Fault fires on the cycle the timer would step onto TIMEOUT.
    wd_hit  = (state_q != S_IDLE) && (timer_q >= T_LAST);
    timer_d = (timer_q >= T_SAT) ? T_SAT : timer_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      cmd_q     <= '0;
      cnt_rst_q <= 1'b1;
      ped_ack_q <= 1'b0;
      cnt_q     <= '0;
      err_q     <= 1'b0;
      pend_q    <= 1'b0;
      timer_q   <= '0;
    end else begin
      ped_ack_q <= 1'b0;
      if (state_q == S_IDLE) begin
        cnt_rst_q <= 1'b1;
        timer_q   <= '0;
        pend_q    <= 1'b0;
        if (en && !err_q) begin
          state_q <= S_INIT;
          cmd_q   <= cmd_of(S_INIT);
        end
      end else if (wd_hit || !en) begin
        err_q     <= err_q | wd_hit;
        state_q   <= S_IDLE;
        cmd_q     <= '0;
        cnt_rst_q <= 1'b1;
        timer_q   <= '0;
        pend_q    <= 1'b0;
      end else if (advance) begin
        state_q   <= next_phase;
        cmd_q     <= cmd_of(next_phase);
        cnt_rst_q <= 1'b1;
        timer_q   <= '0;
        // A request arriving on the clearing edge keeps the request pending.
        if (next_phase == S_RED && pend_q) begin
          ped_ack_q <= 1'b1;
          pend_q    <= ped_req;
        end else begin
          pend_q <= pend_q | ped_req;
        end
        if (state_q == S_RED) cnt_q <= cnt_q + 1'b1;
      end else begin
        cnt_rst_q <= 1'b0;
        timer_q   <= timer_d;
        pend_q    <= pend_q | ped_req;
      end
    end
  end

  assign cmd_flags = cmd_q;
  assign cnt_rst   = cnt_rst_q;
  assign ped_ack   = ped_ack_q;
  assign cycle_cnt = cnt_q;
  assign err       = err_q;

endmodule

// File: tb/tb_tl_ctrl.sv
// Directed bench for tl_ctrl: phase-level reference model compared every cycle,
// plus literal phase lengths and counter values hand-derived from the phase rules.
module tb_tl_ctrl;

  localparam int MIN_G   = 128;
  localparam int TIMEOUT = 2047;
  localparam logic [3:0] C_IDLE = 4'b0000;
  localparam logic [3:0] C_INIT = 4'b0001;
  localparam logic [3:0] C_G    = 4'b0010;
  localparam logic [3:0] C_Y    = 4'b0100;
  localparam logic [3:0] C_R    = 4'b1000;

  logic       clk;
  logic       reset;
  logic       en;
  logic [3:0] int_flags;
  logic       ped_req;
  logic [3:0] cmd_flags;
  logic       cnt_rst;
  logic       ped_ack;
  logic [7:0] cycle_cnt;
  logic       err;

  tl_ctrl #(.MIN_G(MIN_G), .TIMEOUT(TIMEOUT), .PT_W(11)) dut (
    .clk       (clk),
    .reset     (reset),
    .en        (en),
    .int_flags (int_flags),
    .ped_req   (ped_req),
    .cmd_flags (cmd_flags),
    .cnt_rst   (cnt_rst),
    .ped_ack   (ped_ack),
    .cycle_cnt (cycle_cnt),
    .err       (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_pass  = 0;
  int n_total = 0;

  // Reference model: phase index (-1 idle, else flag bit), cycles spent in phase.
  int m_phase = -1;
  int m_age   = 0;
  bit m_pend  = 0;
  int m_cnt   = 0;
  bit m_err   = 0;
  bit e_ack   = 0;
  bit e_rst   = 1;

  // Datapath stub: done flag asserted at this phase cycle (index by phase bit).
  int done_at [4];
  bit all_ones = 0;

  task automatic chk(input string nm, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
  endtask

  task automatic model_update();
    int np;
    bit entered;
    bit fin;
    np      = m_phase;
    entered = 0;
    if (reset) begin
      m_phase = -1; m_age = 0; m_pend = 0; m_cnt = 0; m_err = 0;
      e_ack = 0; e_rst = 1;
      return;
    end
    e_ack = 0;
    if (m_phase < 0) begin
      m_pend = 0;
      if (en && !m_err) begin np = 0; entered = 1; end
    end else if (m_age + 1 >= TIMEOUT) begin
      m_err = 1; np = -1; m_pend = 0;
    end else if (!en) begin
      np = -1; m_pend = 0;
    end else begin
      fin = (m_age >= 2 && int_flags[m_phase]) ||
            (m_phase == 1 && m_pend && m_age >= MIN_G);
      if (fin) begin
        np = (m_phase == 3) ? 1 : m_phase + 1;
        entered = 1;
        if (np == 3 && m_pend) begin e_ack = 1; m_pend = ped_req; end
        else m_pend = m_pend | ped_req;
        if (m_phase == 3) m_cnt = (m_cnt + 1) % 256;
      end else begin
        m_pend = m_pend | ped_req;
      end
    end
    if (np < 0 || entered) begin m_age = 0; e_rst = 1; end
    else begin m_age++; e_rst = 0; end
    m_phase = np;
  endtask

  task automatic step();
    logic [3:0] f;
    f = 4'b0000;
    if (all_ones) f = 4'b1111;
    else if (m_phase >= 0 && m_age == done_at[m_phase]) f[m_phase] = 1'b1;
    int_flags = f;
    @(posedge clk);
    model_update();
    #1;
    chk("cmd_flags", int'(cmd_flags), (m_phase < 0) ? 0 : (1 << m_phase));
    chk("cnt_rst",   int'(cnt_rst),   int'(e_rst));
    chk("ped_ack",   int'(ped_ack),   int'(e_ack));
    chk("cycle_cnt", int'(cycle_cnt), m_cnt);
    chk("err",       int'(err),       int'(m_err));
  endtask

  task automatic run_until(input logic [3:0] tgt, input int budget, output int n);
    n = 0;
    while (1) begin
      step();
      n++;
      if (cmd_flags == tgt) break;
      if (n >= budget) begin
        chk("wait_budget", n, -1);
        break;
      end
    end
  endtask

  int n;
  int g_len;
  int saved_cnt;

  initial begin
    reset = 1'b1; en = 1'b0; ped_req = 1'b0; int_flags = 4'b0000;
    done_at[0] = 1000; done_at[1] = 510; done_at[2] = 509; done_at[3] = 1021;

    // Reset state
    step(); step();
    chk("rst_cmd", int'(cmd_flags), 0);
    chk("rst_cnt_rst", int'(cnt_rst), 1);
    chk("rst_cycle_cnt", int'(cycle_cnt), 0);
    chk("rst_err", int'(err), 0);
    reset = 1'b0;
    step();
    chk("idle_hold_cnt_rst", int'(cnt_rst), 1);

    // Enable: INIT with one-cycle cnt_rst, then full G->Y->R->G loop
    en = 1'b1;
    step();
    chk("init_cmd", int'(cmd_flags), int'(C_INIT));
    chk("init_cnt_rst", int'(cnt_rst), 1);
    run_until(C_G, 3000, n);
    chk("init_len", n, 1001);
    chk("green_entry_cnt_rst", int'(cnt_rst), 1);
    run_until(C_Y, 3000, n);  chk("green_len", n, 511);
    run_until(C_R, 3000, n);  chk("yellow_len", n, 510);
    run_until(C_G, 3000, n);  chk("red_len", n, 1022);
    chk("cycle_cnt_after_red", int'(cycle_cnt), 1);

    // Blanking with all flags high: every phase 3 cycles; also drives the wrap
    all_ones = 1;
    run_until(C_Y, 10, n); chk("blank_g_len", n, 3);
    run_until(C_R, 10, n); chk("blank_y_len", n, 3);
    run_until(C_G, 10, n); chk("blank_r_len", n, 3);
    chk("cycle_cnt_2", int'(cycle_cnt), 2);
    for (int i = 0; i < 254; i++) begin
      run_until(C_Y, 10, n);
      run_until(C_R, 10, n);
      run_until(C_G, 10, n);
    end
    chk("cycle_cnt_wrap", int'(cycle_cnt), 0);
    all_ones = 0;

    // Pedestrian early termination: request at GREEN cycle 10
    done_at[1] = 5000;
    for (int i = 0; i < 10; i++) step();
    ped_req = 1'b1; step(); ped_req = 1'b0;
    run_until(C_Y, 3000, n);
    g_len = 11 + n;
    chk("ped_green_len", g_len, 129);
    run_until(C_R, 3000, n); chk("ped_yellow_len", n, 510);
    chk("ped_ack_first_red", int'(ped_ack), 1);
    ped_req = 1'b1; step(); ped_req = 1'b0;
    chk("ped_ack_one_cycle", int'(ped_ack), 0);
    run_until(C_G, 3000, n); chk("ped_red_len", n, 1021);
    chk("cycle_cnt_after_ped", int'(cycle_cnt), 1);
    run_until(C_Y, 3000, n); chk("ped_repend_green_len", n, 129);

    // en=0 mid-RED, then re-enable through INIT
    run_until(C_R, 3000, n);
    for (int i = 0; i < 100; i++) step();
    saved_cnt = int'(cycle_cnt);
    en = 1'b0; step();
    chk("dis_cmd", int'(cmd_flags), 0);
    chk("dis_cnt_rst", int'(cnt_rst), 1);
    chk("dis_cycle_cnt", int'(cycle_cnt), saved_cnt);
    chk("dis_cycle_cnt_lit", int'(cycle_cnt), 1);
    ped_req = 1'b1; step(); ped_req = 1'b0;
    en = 1'b1; step();
    chk("reen_cmd", int'(cmd_flags), int'(C_INIT));

    // Watchdog: YELLOW done never arrives
    done_at[1] = 510; done_at[2] = 100000;
    run_until(C_G, 3000, n); chk("wd_init_len", n, 1001);
    run_until(C_Y, 3000, n); chk("wd_green_len", n, 511);
    run_until(C_IDLE, 3000, n); chk("wd_yellow_len", n, 2047);
    chk("wd_err", int'(err), 1);
    chk("wd_cnt_rst", int'(cnt_rst), 1);
    en = 1'b0; step(); step();
    en = 1'b1; for (int i = 0; i < 5; i++) step();
    chk("wd_no_restart", int'(cmd_flags), 0);
    reset = 1'b1; step(); reset = 1'b0;
    chk("wd_reset_clears", int'(err), 0);
    step();
    chk("wd_restart_init", int'(cmd_flags), int'(C_INIT));

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
